// File: rtl/branch_rs.sv
// branch_rs: reservation station in front of the branch unit.
// Ports: clk/rst, dispatch_en/dispatch_entry in, full/count out,
//        wb_en/wb_prd wakeup, issue_en/issue_entry/ready issue, flush.
package pkg;
  localparam int PHYS_REG_BITS = 6;
  localparam int ROB_TAG_BITS  = 5;

  typedef struct packed {
    logic [3:0]               alu_op;
    logic [31:0]              immediate;
    logic [31:0]              pc;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     prs1_ready;
    logic                     prs2_ready;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
    logic                     reg_write;
  } rs_entry_t;
endpackage

module branch_rs
  import pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dispatch_en,
  input  rs_entry_t                     dispatch_entry,
  output logic                          full,
  output logic [$clog2(DEPTH):0]        count,
  input  logic [NUM_WB-1:0]             wb_en,
  input  logic [NUM_WB-1:0]
               [PHYS_REG_BITS-1:0]      wb_prd,
  output logic                          issue_en,
  output rs_entry_t                     issue_entry,
  input  logic                          ready,
  input  logic                          flush
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(rs_entry_t);

  rs_entry_t        ent   [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [DEPTH-1:0] wk1;
  logic [DEPTH-1:0] wk2;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] alloc;
  logic             d_wk1;
  logic             d_wk2;
  logic             do_issue;
  logic             do_disp;
  rs_entry_t        disp_w;

  // Wakeup compare for stored slots and for the
  // entry arriving this cycle.
  always_comb begin
    wk1   = '0;
    wk2   = '0;
    d_wk1 = 1'b0;
    d_wk2 = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_prd[k] == ent[i].prs1) wk1[i] = 1'b1;
          if (wb_prd[k] == ent[i].prs2) wk2[i] = 1'b1;
        end
        if (wb_prd[k] == dispatch_entry.prs1) d_wk1 = 1'b1;
        if (wb_prd[k] == dispatch_entry.prs2) d_wk2 = 1'b1;
      end
    end
  end

  always_comb begin
    disp_w            = dispatch_entry;
    disp_w.prs1_ready = dispatch_entry.prs1_ready | d_wk1;
    disp_w.prs2_ready = dispatch_entry.prs2_ready | d_wk2;
  end

  // Lowest-index free slot.
  always_comb begin
    logic hit;
    alloc = '0;
    hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !hit) begin
        alloc[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid[i]
              & ent[i].prs1_ready
              & ent[i].prs2_ready;
    end
  end

  // Oldest eligible: no other eligible slot is older.
  always_comb begin
    logic [DEPTH-1:0] col;
    sel = '0;
    col = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        col[j] = older[j][i];
      end
      sel[i] = elig[i] && ((elig & col) == '0);
    end
  end

  always_comb begin
    logic [EW-1:0] mux;
    mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mux = mux | (ent[i] & {EW{sel[i]}});
    end
    issue_entry = rs_entry_t'(mux);
  end

  assign issue_en = |elig;
  assign do_issue = issue_en & ready;
  assign do_disp  = dispatch_en & ~full;
  assign full     = &valid;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else begin
      valid <= (valid & ~(do_issue ? sel : '0))
             | (do_disp ? alloc : '0);
    end
  end

  // Payload, ready bits and age are don't-care
  // while a slot is invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && alloc[i]) begin
        ent[i] <= disp_w;
      end else begin
        ent[i].prs1_ready <= ent[i].prs1_ready | wk1[i];
        ent[i].prs2_ready <= ent[i].prs2_ready | wk2[i];
      end
    end
  end

  // older[i][j]: slot i was dispatched before slot j.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (do_disp && alloc[i]) begin
          older[i][j] <= 1'b0;
        end else if (do_disp && alloc[j]) begin
          older[i][j] <= valid[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: scoreboard bench for branch_rs.
// Expected issue order is queued at stimulus time.
module tb_branch_rs;
  import pkg::*;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] pc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            dispatch_en;
  rs_entry_t       dispatch_entry;
  logic            full;
  logic [2:0]      count;
  logic [1:0]      wb_en;
  logic [1:0][5:0] wb_prd;
  logic            issue_en;
  rs_entry_t       issue_entry;
  logic            ready;
  logic            flush;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  branch_rs #(.DEPTH(4), .NUM_WB(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .dispatch_en   (dispatch_en),
    .dispatch_entry(dispatch_entry),
    .full          (full),
    .count         (count),
    .wb_en         (wb_en),
    .wb_prd        (wb_prd),
    .issue_en      (issue_en),
    .issue_entry   (issue_entry),
    .ready         (ready),
    .flush         (flush)
  );

  // Every accepted issue must match the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && issue_en && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected got tag=%0d required none",
                 issue_entry.rob_tag);
      end else begin
        e = exp_q.pop_front();
        if (issue_entry.rob_tag !== e.tag ||
            issue_entry.pc !== e.pc) begin
          bad++;
          $display("FAIL issue_order got tag=%0d pc=%h required tag=%0d pc=%h",
                   issue_entry.rob_tag, issue_entry.pc, e.tag, e.pc);
        end
      end
    end
  end

  function automatic rs_entry_t mk(
    input logic [4:0]  tag,
    input logic [31:0] pc,
    input logic [5:0]  p1,
    input logic [5:0]  p2,
    input logic        r1,
    input logic        r2
  );
    rs_entry_t x;
    x.alu_op     = 4'h1;
    x.immediate  = 32'h40 + 32'(tag);
    x.pc         = pc;
    x.prd        = 6'(tag) + 6'd32;
    x.prs1       = p1;
    x.prs2       = p2;
    x.prs1_ready = r1;
    x.prs2_ready = r2;
    x.rob_tag    = tag;
    x.reg_write  = 1'b0;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] t, input logic [31:0] p);
    exp_t x;
    x.tag = t;
    x.pc  = p;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    dispatch_en = 1'b0;
    wb_en       = '0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    ready          = 1'b0;
    dispatch_entry = '0;
    wb_prd         = '0;
    idle();
    repeat (2) step();
    total++;
    if (full !== 1'b0) begin
      bad++;
      $display("FAIL reset_full got %b required 0", full);
    end
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL reset_count got %0d required 0", count);
    end
    total++;
    if (issue_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_issue_en got %b required 0", issue_en);
    end
    total++;
    if (issue_entry !== rs_entry_t'('0)) begin
      bad++;
      $display("FAIL reset_issue_entry got %h required 0", issue_entry);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    ready          = 1'b1;
    dispatch_en    = 1'b1;
    dispatch_entry = mk(5'd0, 32'h1000, 6'd1, 6'd2, 1'b1, 1'b1);
    push(5'd0, 32'h1000);
    step();
    idle();
    total++;
    if (issue_en !== 1'b1 || issue_entry.pc !== 32'h1000 ||
        issue_entry.rob_tag !== 5'd0) begin
      bad++;
      $display("FAIL single_offer got en=%b pc=%h tag=%0d required en=1 pc=1000 tag=0",
               issue_en, issue_entry.pc, issue_entry.rob_tag);
    end
    total++;
    if (count !== 3'd1) begin
      bad++;
      $display("FAIL single_count1 got %0d required 1", count);
    end
    step();
    total++;
    if (count !== 3'd0 || issue_en !== 1'b0) begin
      bad++;
      $display("FAIL single_empty got count=%0d en=%b required 0 0",
               count, issue_en);
    end
  endtask

  task automatic test_wakeup();
    ready          = 1'b1;
    dispatch_en    = 1'b1;
    dispatch_entry = mk(5'd1, 32'h1100, 6'd5, 6'd6, 1'b0, 1'b1);
    step();
    dispatch_entry = mk(5'd2, 32'h1200, 6'd7, 6'd8, 1'b1, 1'b1);
    push(5'd2, 32'h1200);
    step();
    idle();
    step();
    total++;
    if (issue_en !== 1'b0 || count !== 3'd1) begin
      bad++;
      $display("FAIL wake_wait got en=%b count=%0d required 0 1",
               issue_en, count);
    end
    wb_en[0]  = 1'b1;
    wb_prd[0] = 6'd5;
    total++;
    if (issue_en !== 1'b0) begin
      bad++;
      $display("FAIL wake_no_bypass got %b required 0", issue_en);
    end
    push(5'd1, 32'h1100);
    step();
    idle();
    total++;
    if (issue_en !== 1'b1 || issue_entry.rob_tag !== 5'd1) begin
      bad++;
      $display("FAIL wake_offer got en=%b tag=%0d required 1 1",
               issue_en, issue_entry.rob_tag);
    end
    step();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL wake_drain got %0d required 0", count);
    end
  endtask

  task automatic test_hold();
    ready          = 1'b0;
    dispatch_en    = 1'b1;
    dispatch_entry = mk(5'd3, 32'h1300, 6'd1, 6'd2, 1'b1, 1'b1);
    push(5'd3, 32'h1300);
    step();
    dispatch_entry = mk(5'd4, 32'h1400, 6'd1, 6'd2, 1'b1, 1'b1);
    push(5'd4, 32'h1400);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (issue_en !== 1'b1 || issue_entry.rob_tag !== 5'd3) begin
        bad++;
        $display("FAIL hold_offer cyc=%0d got en=%b tag=%0d required 1 3",
                 i, issue_en, issue_entry.rob_tag);
      end
      step();
    end
    ready = 1'b1;
    step();
    total++;
    if (issue_entry.rob_tag !== 5'd4) begin
      bad++;
      $display("FAIL hold_next got tag=%0d required 4",
               issue_entry.rob_tag);
    end
    step();
    total++;
    if (issue_en !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL hold_drain got en=%b pending=%0d required 0 0",
               issue_en, exp_q.size());
    end
  endtask

  task automatic test_full();
    ready       = 1'b0;
    dispatch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dispatch_entry = mk(5'(10 + i), 32'h2000 + 32'(i * 4),
                          6'd12, 6'd13, 1'b0, 1'b1);
      step();
    end
    dispatch_en = 1'b0;
    total++;
    if (full !== 1'b1 || count !== 3'd4 || issue_en !== 1'b0) begin
      bad++;
      $display("FAIL full_state got full=%b count=%0d en=%b required 1 4 0",
               full, count, issue_en);
    end
    dispatch_en    = 1'b1;
    dispatch_entry = mk(5'd14, 32'h2010, 6'd12, 6'd13, 1'b0, 1'b1);
    step();
    idle();
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL full_drop got %0d required 4", count);
    end
    wb_en[1]  = 1'b1;
    wb_prd[1] = 6'd12;
    ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(5'(10 + i), 32'h2000 + 32'(i * 4));
    end
    step();
    idle();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
    step();
    total++;
    if (exp_q.size() != 0 || count !== 3'd0) begin
      bad++;
      $display("FAIL full_drain got pending=%0d count=%0d required 0 0",
               exp_q.size(), count);
    end
  endtask

  task automatic test_coincident();
    ready          = 1'b1;
    dispatch_en    = 1'b1;
    dispatch_entry = mk(5'd7, 32'h3000, 6'd3, 6'd9, 1'b1, 1'b0);
    wb_en[1]       = 1'b1;
    wb_prd[1]      = 6'd9;
    push(5'd7, 32'h3000);
    step();
    idle();
    total++;
    if (issue_en !== 1'b1 || issue_entry.rob_tag !== 5'd7) begin
      bad++;
      $display("FAIL coinc_offer got en=%b tag=%0d required 1 7",
               issue_en, issue_entry.rob_tag);
    end
    step();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL coinc_drain got %0d required 0", count);
    end
  endtask

  task automatic test_flush();
    ready       = 1'b0;
    dispatch_en = 1'b1;
    dispatch_entry = mk(5'd20, 32'h4000, 6'd1, 6'd2, 1'b1, 1'b1);
    step();
    dispatch_entry = mk(5'd21, 32'h4004, 6'd1, 6'd2, 1'b1, 1'b1);
    step();
    total++;
    if (count !== 3'd2) begin
      bad++;
      $display("FAIL flush_pre got %0d required 2", count);
    end
    dispatch_entry = mk(5'd22, 32'h4008, 6'd1, 6'd2, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    idle();
    total++;
    if (count !== 3'd0 || issue_en !== 1'b0) begin
      bad++;
      $display("FAIL flush_post got count=%0d en=%b required 0 0",
               count, issue_en);
    end
    ready = 1'b1;
    repeat (2) step();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL flush_retained got %0d required 0", count);
    end
  endtask

  task automatic test_back_to_back();
    ready       = 1'b1;
    dispatch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dispatch_entry = mk(5'(24 + i), 32'h5000 + 32'(i * 8),
                          6'd1, 6'd2, 1'b1, 1'b1);
      push(5'(24 + i), 32'h5000 + 32'(i * 8));
      step();
    end
    idle();
    total++;
    if (count !== 3'd1 || exp_q.size() != 1) begin
      bad++;
      $display("FAIL b2b_rate got count=%0d pending=%0d required 1 1",
               count, exp_q.size());
    end
    step();
    total++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got count=%0d pending=%0d required 0 0",
               count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup();
    test_hold();
    test_full();
    test_coincident();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_rs.md
# branch_rs

Reservation station for the branch unit: holds dispatched branch/JALR micro-ops until both source physical registers are ready, then issues the oldest ready entry to `branch_unit` through its `issue_en`/`issue_entry`/`ready` handshake. It sits between rename/dispatch and the branch unit. It snoops writeback buses for wakeup and is emptied by the pipeline-wide `flush`.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- NUM_WB, 2, number of writeback/wakeup ports snooped
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dispatch_en  in  1  write `dispatch_entry` into a free slot this cycle
- dispatch_entry  in  rs_entry_t  micro-op; fields used: prs1, prs2, prs1_ready, prs2_ready; all other fields (alu_op, immediate, pc, prd, rob_tag, reg_write) are carried unchanged
- full  out  1  all DEPTH slots valid
- count  out  $clog2(DEPTH)+1  number of valid slots
- wb_en  in  [NUM_WB]  wakeup valid per port
- wb_prd  in  [NUM_WB][PHYS_REG_BITS]  physical register written
- issue_en  out  1  an entry is offered to branch_unit
- issue_entry  out  rs_entry_t  offered entry; it is also the PRF read address source (prs1/prs2)
- ready  in  1  branch_unit accepts the offer this cycle
- flush  in  1  discard all entries

## Operation
- Per slot: valid bit, stored entry, and the two ready bits (initialised from `dispatch_entry`).
- Dispatch: if `dispatch_en && !full`, write into the lowest-index free slot. If `dispatch_en && full`, drop silently; the dispatcher must not do this.
- Age: an age matrix (older[i][j]) records dispatch order. A new entry is younger than every valid entry.
- Wakeup: for every valid slot and every port k with `wb_en[k]`, set prsN_ready when `wb_prd[k] == prsN`. A slot being dispatched in the same cycle also compares against that cycle's wakeups, so a wakeup coincident with dispatch is not lost.
- Select: eligible = valid && prs1_ready && prs2_ready. `issue_en` = any eligible. `issue_entry` = oldest eligible. Selection is combinational from registered state only; same-cycle wakeups do not bypass.
- Issue: on `issue_en && ready`, clear the selected slot's valid at the clock edge. If `!ready`, hold; the same or an older entry is offered next cycle.
- Simultaneous issue and dispatch: both take effect. `full` is computed from registered valids, so a freed slot is reusable only the next cycle.
- Flush: all valids cleared at the edge. Flush beats dispatch, wakeup and issue in the same cycle. `issue_en` may still be high during the flush cycle; branch_unit ignores it under flush.
- Reset: identical to flush. Matrix and ready bits are don't-care when the slot is invalid.

## Timing
- Reset values: full=0, count=0, issue_en=0, issue_entry=0.
- Dispatch at edge N: the entry can issue at the earliest in cycle N+1 (`issue_en` high after edge N) if its ready bits were set at dispatch or by a coincident wakeup.
- Wakeup at edge N: the woken entry is eligible from cycle N+1.
- Issue accepted at edge N: branch_unit registers the result, and completion is visible after edge N+1.
- count and full update one edge after dispatch, issue or flush.
- Throughput: one issue per cycle with `ready` held high.

## Test plan
- Reset, then dispatch a BEQ with both sources ready (rob_tag=0, pc=0x1000) → `issue_en` rises the next cycle with the same pc and rob_tag; with `ready`=1 the slot empties and count returns to 0.
- Dispatch A (rob_tag=1, prs1=5 not ready), then B (rob_tag=2, both ready) → B issues first. Then `wb_en[0]`=1, `wb_prd[0]`=5 → A issues the cycle after the wakeup.
- Dispatch C and D, both ready, in consecutive cycles (tags 3,4), with `ready`=0 for 3 cycles → `issue_entry` stays tag 3. `ready`=1 → tag 3 then tag 4 on consecutive cycles.
- Fill 4 entries (none ready) → full=1, count=4. A fifth dispatch is dropped. A wakeup on `wb_en[1]` matching all entries' prs → 4 issues in oldest-first order.
- Dispatch tag 7 with prs2=9 not ready in the same cycle as `wb_prd[1]`=9 → tag 7 is issued the next cycle.
- Entries valid plus `flush`=1 coincident with a dispatch → count=0 and `issue_en`=0 after the edge. The dispatched entry is not retained.
